// File: rtl/sll_multicycle_pkg.sv
// Shared definitions for the iterative shift-left-logical unit:
// FSM state encoding and default operand/amount widths.
package sll_multicycle_pkg;

   localparam int DATA_WIDTH_DEF  = 32;
   localparam int SHAMT_WIDTH_DEF = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/sll_multicycle_stage.sv
// One binary-weighted left-shift stage: shifts by 2^K when enabled,
// zero-filling the LSBs and dropping bits past the MSB.
module sll_multicycle_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 0
) (
   input  logic [DATA_WIDTH-1:0] i_work,
   input  logic                  i_en,
   output logic [DATA_WIDTH-1:0] o_work
);

   assign o_work = i_en ? (i_work << (2 ** K)) : i_work;

endmodule

// File: rtl/sll_multicycle.sv
// Iterative shift-left-logical: one 2^k stage per clock, fixed SHAMT_WIDTH
// shift cycles, result published with a one-cycle ready pulse.
import sll_multicycle_pkg::*;

module sll_multicycle #(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   ctrl_start,
   input  logic [DATA_WIDTH-1:0]  data_operandA,
   input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
   output logic [DATA_WIDTH-1:0]  sll_out,
   output logic                   data_resultRDY,
   output logic                   busy
);

   localparam int STG_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
   localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_WIDTH - 1);

   state_t                  r_state;
   logic [DATA_WIDTH-1:0]   r_work;
   logic [SHAMT_WIDTH-1:0]  r_amt;
   logic [STG_W-1:0]        r_stage;
   logic [DATA_WIDTH-1:0]   r_result;

   state_t                  w_state_next;
   logic [DATA_WIDTH-1:0]   w_work_next;
   logic [SHAMT_WIDTH-1:0]  w_amt_next;
   logic [STG_W-1:0]        w_stage_next;
   logic [DATA_WIDTH-1:0]   w_result_next;

   logic [DATA_WIDTH-1:0]   w_stage_out [SHAMT_WIDTH];
   logic [DATA_WIDTH-1:0]   w_stage_sel;

   // Every stage sees the same working value; the counter picks which one is applied.
   genvar gi;
   generate
      for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
         sll_multicycle_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .K          (gi)
         ) u_stage (
            .i_work (r_work),
            .i_en   (r_amt[gi]),
            .o_work (w_stage_out[gi])
         );
      end
   endgenerate

   assign w_stage_sel = w_stage_out[r_stage];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_work   <= '0;
         r_amt    <= '0;
         r_stage  <= '0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_next;
         r_work   <= w_work_next;
         r_amt    <= w_amt_next;
         r_stage  <= w_stage_next;
         r_result <= w_result_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_work_next   = r_work;
      w_amt_next    = r_amt;
      w_stage_next  = r_stage;
      w_result_next = r_result;
      case (r_state)
         IDLE, DONE: begin
            // DONE accepts a new request directly so back-to-back ops take 6 cycles.
            if (ctrl_start) begin
               w_work_next  = data_operandA;
               w_amt_next   = ctrl_shiftamt;
               w_stage_next = '0;
               w_state_next = SHIFT;
            end else begin
               w_state_next = IDLE;
            end
         end
         SHIFT: begin
            w_work_next  = w_stage_sel;
            w_stage_next = r_stage + STG_W'(1);
            if (r_stage == LAST_STAGE) begin
               w_result_next = w_stage_sel;
               w_stage_next  = '0;
               w_state_next  = DONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign sll_out        = r_result;
   assign data_resultRDY = (r_state == DONE);
   assign busy           = (r_state == SHIFT);

endmodule

// File: doc/sll_multicycle.md
Name: sll_multicycle

Overview:
- Iterative 32-bit shift-left-logical unit for the ALU/multdiv side of the CPU.
- It is the left-direction counterpart of the combinational arithmetic-right shifter.
- It applies one binary-weighted stage (1, 2, 4, 8, 16) per clock, using a start/ready handshake.
- Lets the datapath trade the full barrel-shifter area for fixed multi-cycle latency.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width. Must equal log2(DATA_WIDTH); this is also the number of SHIFT cycles.

Ports:
- clock  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_start  input  1  request strobe, sampled each rising edge.
- data_operandA  input  DATA_WIDTH  value to shift, captured on an accepted start.
- ctrl_shiftamt  input  SHAMT_WIDTH  shift amount, captured on an accepted start.
- sll_out  output  DATA_WIDTH  last completed result, held stable between completions.
- data_resultRDY  output  1  one-cycle pulse marking a new sll_out.
- busy  output  1  high while an operation is in progress (SHIFT state).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; work, amt_q, stage counter = 0.
  - sll_out=0; data_resultRDY=0; busy=0.
  - Deassertion takes effect at the next rising edge.
- States:
  - IDLE: waits for start.
  - SHIFT: stages 0..SHAMT_WIDTH-1.
  - DONE: one cycle, result published.
- IDLE:
  - ctrl_start=1 at edge E0 -> capture work<=data_operandA, amt_q<=ctrl_shiftamt, stage<=0, go to SHIFT.
  - busy=1 from E0 onward.
- SHIFT, each edge for stage k:
  - If amt_q[k]=1: work<=work<<(2^k), zero-fill LSBs, discard bits shifted out the MSB.
  - Otherwise: work unchanged.
  - stage<=k+1.
  - After the k=SHAMT_WIDTH-1 edge (E5 for the default): sll_out<=final work, data_resultRDY<=1, busy<=0, state<=DONE.
- DONE:
  - data_resultRDY is high for exactly this one cycle.
  - Next edge: data_resultRDY<=0. State goes to SHIFT if ctrl_start=1 (capture as in IDLE), else to IDLE.
- Latency:
  - start sampled at E0 -> result valid and RDY high in the cycle after E5.
  - Fixed 5 SHIFT edges regardless of shift amount, including shamt=0.
  - Throughput: one operation per 6 cycles when back-to-back.
- ctrl_start while busy=1 is ignored. No queuing, no error flag; captured operands are unaffected.
- data_operandA/ctrl_shiftamt are don't-care except on the accepting edge. Changes mid-operation must not alter the result.
- sll_out changes only on the completing edge or on reset. It holds the previous result throughout SHIFT.
- Reset asserted mid-SHIFT aborts the operation: no RDY pulse, sll_out=0, IDLE.
- Result equals (data_operandA << ctrl_shiftamt) mod 2^DATA_WIDTH for all operand/amount pairs.

Decomposition:
- Shared package (e.g. sll_pkg):
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - DATA_WIDTH/SHAMT_WIDTH defaults.
- Sub-module sll_stage: combinational, parameterised by stage index k.
  - Inputs: work, enable bit. Output: work<<(2^k) when enabled, else work.
  - Top instantiates one copy per stage and selects the copy indexed by the stage counter. A single variable-shift mux by 2^stage is also acceptable.
- FSM, counter and registers live in the top.

Test Plan:
- Reset: hold reset_n=0 with random inputs and toggling clock -> sll_out=0, data_resultRDY=0, busy=0. Assert reset_n asynchronously mid-cycle -> outputs clear without waiting for an edge.
- Basic: operandA=0x0000_0001, shamt=31, start 1 cycle -> busy high 5 cycles. RDY high only in the 6th cycle after start with sll_out=0x8000_0000; RDY low the next cycle; sll_out holds.
- Zero fill / shamt 0:
  - 0xFFFF_FFFF shamt=4 -> 0xFFFF_FFF0.
  - Then 0x1234_5678 shamt=0 -> 0x1234_5678 after the same 6-cycle latency.
- Busy protection: start 0xA5A5_A5A5 shamt=8, then pulse start with 0x1 shamt=1 and change inputs during SHIFT -> single RDY with 0xA5A5_A500. No second result.
- Back-to-back: hold start=1 continuously with 0x0000_00FF shamt=16 then 0x8000_0001 shamt=1 -> results 0x00FF_0000 then 0x0000_0002. RDY pulses 6 cycles apart; second op is accepted in the DONE cycle.
- Abort: start 0x0000_0003 shamt=2, assert reset_n low at stage 2, release, then start 0x0000_0003 shamt=2 again -> no RDY for the aborted op; sll_out=0 until the new op yields 0x0000_000C.
